selector_rr_arbiter: RTL

Round-robin arbiter that shares one 4:1 selector output among four requesters. It samples four request lines and grants the selector to exactly one requester at a time. It drives the selector's `sel[1:0]` together with a one-hot grant, and bounds each tenure to `HOLD_MAX` cycles when others are waiting. It sits directly in front of the 4:1 selector; requester data buses connect to selector inputs A–D in index order 0–3.

---
 rtl/selector_rr_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/selector_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 selector.
// Grants one requester at a time, bounding tenure to HOLD_MAX under contention.
module selector_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  localparam int CW = $clog2(HOLD_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  output logic [3:0]    grant,
  output logic [1:0]    sel,
  output logic          busy,
  output logic [CW-1:0] hold_cnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [CW-1:0] HMAX = CW'(HOLD_MAX);

  state_t        state, state_n;
  logic [1:0]    last, last_n;
  logic [1:0]    owner, owner_n;
  logic [3:0]    grant_n;
  logic          busy_n;
  logic [CW-1:0] hold_n;

  logic [1:0] base;
  logic [3:0] mask;
  logic [1:0] pick;
  logic       found;
  logic       rel;
  logic       pre;

  assign sel = owner;

  // In GRANT the search starts after the owner, which is never re-eligible
  always_comb begin
    base  = last;
    mask  = req;
    if (state == GRANT) begin
      base = owner;
      mask = req & ~(4'b0001 << owner);
    end
    found = 1'b0;
    pick  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = base + 2'(k);
      if (!found && mask[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rel = !req[owner];
  assign pre = (hold_cnt == HMAX) && (|mask);

  always_comb begin
    state_n = state;
    last_n  = last;
    owner_n = owner;
    grant_n = grant;
    busy_n  = busy;
    hold_n  = hold_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          owner_n = pick;
          grant_n = 4'b0001 << pick;
          busy_n  = 1'b1;
          hold_n  = CW'(1);
        end
      end
      GRANT: begin
        if (rel || pre) begin
          last_n = owner;
          if (found) begin
            owner_n = pick;
            grant_n = 4'b0001 << pick;
            hold_n  = CW'(1);
          end else begin
            state_n = IDLE;
            grant_n = 4'b0000;
            busy_n  = 1'b0;
            hold_n  = '0;
          end
        end else if (hold_cnt != HMAX) begin
          hold_n = hold_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= 2'd3;
      owner    <= 2'd0;
      grant    <= 4'b0000;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      owner    <= owner_n;
      grant    <= grant_n;
      busy     <= busy_n;
      hold_cnt <= hold_n;
    end
  end

endmodule
